// File: rtl/period_tag_tx.sv
// period_tag_tx
//   Turns each tick from the frontend period timer into an 8-byte time-tag
//   packet and sends it over a valid/ready byte stream:
//     byte0    = {HDR_NIBBLE, 3'b000, drop}
//     byte1..6 = period[47:40] .. period[7:0]
//     last     = XOR of all preceding bytes
//   A one-deep pending slot holds one tick that arrives while a packet is in
//   flight. Any further tick is discarded, which sets the sticky overrun flag
//   and the drop bit of the next header.
//
//   Optional build macro PERIOD_TAG_DROPCNT_EN:
//     - adds the drop_count output, a saturating count of discarded ticks;
//     - extends the packet to 10 bytes. Bytes 7..8 carry drop_count MSB first,
//       captured when byte0 is loaded. Byte 9 is the checksum.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   period_done  single-cycle tick from the period timer
//   period       period count, sampled when period_done=1
//   tx_data      packet byte (registered)
//   tx_valid     tx_data valid (registered)
//   tx_ready     downstream accepts the byte when tx_valid && tx_ready
//   busy         packet in flight or pending slot full (registered)
//   overrun      sticky, set on any dropped tick
//   drop_count   (macro only) saturating dropped-tick count
module period_tag_tx #(
  parameter logic [3:0] HDR_NIBBLE = 4'hF,
  parameter int         PERIOD_W   = 48
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                period_done,
  input  logic [PERIOD_W-1:0] period,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic                overrun
`ifdef PERIOD_TAG_DROPCNT_EN
  ,
  output logic [15:0]         drop_count
`endif
);

  if (PERIOD_W != 48) begin : g_bad_width
    $error("period_tag_tx: PERIOD_W must be 48");
  end

`ifdef PERIOD_TAG_DROPCNT_EN
  localparam logic [3:0] LAST_IDX = 4'd9;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [47:0] r_per;
  logic [47:0] r_slot;
  logic        r_slot_full;
  logic        r_drop;
  logic [7:0]  r_csum;
  logic [7:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_busy;
  logic        r_overrun;
`ifdef PERIOD_TAG_DROPCNT_EN
  logic [15:0] r_dcnt;
  logic [15:0] r_dsnap;
`endif

  logic        w_hs;
  logic        w_last_hs;
  logic        w_load;
  logic [47:0] w_src;
  logic [7:0]  w_hdr;
  logic        w_slot_wr;
  logic        w_slot_full_n;
  logic        w_drop;
  state_t      w_state_n;
  logic [3:0]  w_nidx;
  logic [7:0]  w_next_byte;

  assign w_hs      = r_tx_valid & tx_ready;
  assign w_last_hs = (r_state == SEND) & w_hs & (r_idx == LAST_IDX);
  // A new packet starts from IDLE, or directly after the final handshake,
  // whenever a tick is waiting in the slot or arriving now.
  assign w_load    = ((r_state == IDLE) | w_last_hs) & (r_slot_full | period_done);
  // The older (slotted) tick always goes first.
  assign w_src     = r_slot_full ? r_slot : period;
  assign w_hdr     = {HDR_NIBBLE, 3'b000, r_drop};
  // The slot takes the tick either while it drains (tick goes in behind it)
  // or when it is empty during a packet that is not finishing.
  assign w_slot_wr = period_done &
                     ((w_load & r_slot_full) |
                      (~w_load & (r_state == SEND) & ~r_slot_full));
  assign w_slot_full_n = w_slot_wr | (r_slot_full & ~w_load);
  assign w_drop    = period_done & (r_state == SEND) & r_slot_full & ~w_load;
  assign w_state_n = w_load ? SEND : (w_last_hs ? IDLE : r_state);

  // Byte that follows the one currently on tx_data.
  always_comb begin
    w_nidx      = r_idx + 4'd1;
    w_next_byte = r_csum;
    if (w_nidx != LAST_IDX) begin
      case (w_nidx)
        4'd1:    w_next_byte = r_per[47:40];
        4'd2:    w_next_byte = r_per[39:32];
        4'd3:    w_next_byte = r_per[31:24];
        4'd4:    w_next_byte = r_per[23:16];
        4'd5:    w_next_byte = r_per[15:8];
        4'd6:    w_next_byte = r_per[7:0];
`ifdef PERIOD_TAG_DROPCNT_EN
        4'd7:    w_next_byte = r_dsnap[15:8];
        4'd8:    w_next_byte = r_dsnap[7:0];
`endif
        default: w_next_byte = r_csum;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_idx       <= 4'd0;
      r_per       <= '0;
      r_slot      <= '0;
      r_slot_full <= 1'b0;
      r_drop      <= 1'b0;
      r_csum      <= 8'h00;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef PERIOD_TAG_DROPCNT_EN
      r_dcnt      <= 16'h0000;
      r_dsnap     <= 16'h0000;
`endif
    end else begin
      r_state     <= w_state_n;
      r_slot_full <= w_slot_full_n;
      r_busy      <= (w_state_n == SEND) | w_slot_full_n;
      if (w_slot_wr) begin
        r_slot <= period;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
        r_drop    <= 1'b1;
`ifdef PERIOD_TAG_DROPCNT_EN
        if (r_dcnt != 16'hFFFF) begin
          r_dcnt <= r_dcnt + 16'd1;
        end
`endif
      end

      if (w_load) begin
        // A drop never coincides with a load, so clearing r_drop here is safe.
        r_per      <= w_src;
        r_tx_data  <= w_hdr;
        r_csum     <= w_hdr;
        r_idx      <= 4'd0;
        r_drop     <= 1'b0;
        r_tx_valid <= 1'b1;
`ifdef PERIOD_TAG_DROPCNT_EN
        r_dsnap    <= r_dcnt;
`endif
      end else if (w_last_hs) begin
        r_tx_valid <= 1'b0;
        r_idx      <= 4'd0;
      end else if ((r_state == SEND) && w_hs) begin
        r_idx     <= w_nidx;
        r_tx_data <= w_next_byte;
        r_csum    <= r_csum ^ w_next_byte;
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign overrun  = r_overrun;
`ifdef PERIOD_TAG_DROPCNT_EN
  assign drop_count = r_dcnt;
`endif

endmodule

// File: tb/tb_period_tag_tx.sv
module tb_period_tag_tx;

`ifdef PERIOD_TAG_DROPCNT_EN
  localparam int LEN = 10;
`else
  localparam int LEN = 8;
`endif

  logic        clk;
  logic        rst;
  logic        period_done;
  logic [47:0] period;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        overrun;
`ifdef PERIOD_TAG_DROPCNT_EN
  logic [15:0] drop_count;
`endif

  period_tag_tx #(.HDR_NIBBLE(4'hF), .PERIOD_W(48)) dut (
    .clk        (clk),
    .rst        (rst),
    .period_done(period_done),
    .period     (period),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .overrun    (overrun)
`ifdef PERIOD_TAG_DROPCNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Packet-level reference model.
  bit          m_valid;
  logic [7:0]  m_bytes[$];
  int          m_pos;
  bit          m_pend_full;
  logic [47:0] m_pend;
  bit          m_drop;
  bit          m_overrun;
  logic [15:0] m_dcnt;
  int          m_started;
  int          m_drops;
  int          ticks;

  // Receiver side.
  logic [7:0]  rx[$];
  logic [7:0]  last_pkt[$];
  int          rx_pkts;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic start_pkt(input logic [47:0] p);
    logic [7:0] x;
    m_bytes = {};
    m_bytes.push_back({4'hF, 3'b000, m_drop});
    for (int i = 0; i < 6; i++) m_bytes.push_back(p[47-8*i -: 8]);
`ifdef PERIOD_TAG_DROPCNT_EN
    m_bytes.push_back(m_dcnt[15:8]);
    m_bytes.push_back(m_dcnt[7:0]);
`endif
    x = 8'h00;
    foreach (m_bytes[i]) x ^= m_bytes[i];
    m_bytes.push_back(x);
    m_drop    = 1'b0;
    m_pos     = 0;
    m_valid   = 1'b1;
    m_started++;
  endtask

  task automatic model_step(input bit pd, input logic [47:0] p, input bit rdy, input bit rn);
    bit hs;
    bit free;
    if (!rn) begin
      m_valid = 0; m_pos = 0; m_pend_full = 0; m_drop = 0;
      m_overrun = 0; m_dcnt = 16'h0; m_bytes = {};
    end else begin
      hs   = m_valid && rdy;
      free = !m_valid || (hs && m_pos == LEN - 1);
      if (free) begin
        if (m_pend_full) begin
          start_pkt(m_pend);
          if (pd) m_pend = p;
          else m_pend_full = 0;
        end else if (pd) begin
          start_pkt(p);
        end else begin
          m_valid = 0;
        end
      end else begin
        if (hs) m_pos++;
        if (pd) begin
          if (!m_pend_full) begin
            m_pend = p;
            m_pend_full = 1;
          end else begin
            m_overrun = 1;
            m_drop = 1;
            m_drops++;
            if (m_dcnt != 16'hFFFF) m_dcnt++;
          end
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, record any handshake, advance the model,
  // then compare every meaningful output just after the edge.
  task automatic step(input bit pd, input logic [47:0] p, input bit rdy, input bit rn);
    logic       prev_valid;
    logic [7:0] prev_data;
    logic [7:0] x;
    rst = rn; period_done = pd; period = p; tx_ready = rdy;
    prev_valid = tx_valid;
    prev_data  = tx_data;
    if (!rn) begin
      rx = {};
    end else if (tx_valid && rdy) begin
      rx.push_back(tx_data);
      if (rx.size() == LEN) begin
        x = 8'h00;
        for (int i = 0; i < LEN - 1; i++) x ^= rx[i];
        chk("checksum", {24'h0, rx[LEN-1]}, {24'h0, x});
        last_pkt = rx;
        rx_pkts++;
        rx = {};
      end
    end
    if (rn && pd) ticks++;
    model_step(pd, p, rdy, rn);
    @(posedge clk);
    #1;
    chk("tx_valid", {31'h0, tx_valid}, {31'h0, m_valid});
    chk("busy", {31'h0, busy}, {31'h0, (m_valid | m_pend_full)});
    chk("overrun", {31'h0, overrun}, {31'h0, m_overrun});
    if (m_valid) chk("tx_data", {24'h0, tx_data}, {24'h0, m_bytes[m_pos]});
`ifdef PERIOD_TAG_DROPCNT_EN
    chk("drop_count", {16'h0, drop_count}, {16'h0, m_dcnt});
`endif
    if (rn && prev_valid && !rdy) chk("stall_hold", {24'h0, tx_data}, {24'h0, prev_data});
    @(negedge clk);
  endtask

  logic [7:0] exp1[$];
  logic [47:0] rp;
  bit          rpd;
  int          issued;
  int          cyc;

  initial begin
    rst = 1'b0; period_done = 1'b0; period = '0; tx_ready = 1'b0;
    m_started = 0; m_drops = 0; ticks = 0; rx_pkts = 0;
`ifdef PERIOD_TAG_DROPCNT_EN
    exp1 = '{8'hF0, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'h00, 8'h00, 8'hD2};
`else
    exp1 = '{8'hF0, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hD2};
`endif
    @(negedge clk);

    // Reset state
    step(0, 48'h0, 1, 0);
    step(0, 48'h0, 1, 0);
    chk("reset_tx_data", {24'h0, tx_data}, 32'h0);
    chk("reset_busy", {31'h0, busy}, 32'h0);
    step(0, 48'h0, 1, 1);

    // Single packet, ready always high
    step(1, 48'h0123_4567_89AB, 1, 1);
    chk("t1_first_byte", {24'h0, tx_data}, 32'hF0);
    for (int i = 0; i < LEN; i++) step(0, 48'h0, 1, 1);
    for (int i = 0; i < LEN; i++) chk("t1_byte", {24'h0, last_pkt[i]}, {24'h0, exp1[i]});
    chk("t1_idle_busy", {31'h0, busy}, 32'h0);

    // Ready toggling every cycle
    step(1, 48'hA5A5_0F0F_3C3C, 0, 1);
    for (int i = 0; i < 2 * LEN + 2; i++) step(0, 48'h0, (i % 2) == 1, 1);
    chk("t2_pkts", rx_pkts, 2);
    chk("t2_byte6", {24'h0, last_pkt[6]}, 32'h3C);

    // Tick on the final handshake: back-to-back, no drop
    step(1, 48'h1111_1111_1111, 1, 1);
    for (int i = 0; i < LEN - 1; i++) step(0, 48'h0, 1, 1);
    step(1, 48'h2222_2222_2222, 1, 1);
    chk("t4_valid", {31'h0, tx_valid}, 32'h1);
    chk("t4_hdr", {24'h0, tx_data}, 32'hF0);
    chk("t4_overrun", {31'h0, overrun}, 32'h0);
    for (int i = 0; i < LEN + 2; i++) step(0, 48'h0, 1, 1);

    // Three ticks with ready held low: third one is dropped
    step(1, 48'h1, 0, 1);
    step(0, 48'h0, 0, 1);
    step(1, 48'h2, 0, 1);
    step(0, 48'h0, 0, 1);
    step(1, 48'h3, 0, 1);
    chk("t3_overrun", {31'h0, overrun}, 32'h1);
`ifdef PERIOD_TAG_DROPCNT_EN
    chk("t3_drop_count", {16'h0, drop_count}, 32'h1);
`endif
    for (int i = 0; i < 2 * LEN + 2; i++) step(0, 48'h0, 1, 1);
    chk("t3_hdr2", {24'h0, last_pkt[0]}, 32'hF1);
    chk("t3_per2", {24'h0, last_pkt[6]}, 32'h02);
`ifdef PERIOD_TAG_DROPCNT_EN
    chk("t3_dc_hi", {24'h0, last_pkt[7]}, 32'h00);
    chk("t3_dc_lo", {24'h0, last_pkt[8]}, 32'h01);
`endif

    // Reset at byte 3 with the slot full
    step(1, 48'hDEAD_BEEF_0001, 1, 1);
    step(1, 48'hDEAD_BEEF_0002, 1, 1);
    step(0, 48'h0, 1, 1);
    step(0, 48'h0, 1, 1);
    step(0, 48'h0, 1, 0);
    chk("t5_valid", {31'h0, tx_valid}, 32'h0);
    chk("t5_overrun", {31'h0, overrun}, 32'h0);
    for (int i = 0; i < 5; i++) step(0, 48'h0, 1, 1);
    chk("t5_no_residual", {31'h0, tx_valid}, 32'h0);
    chk("t5_busy", {31'h0, busy}, 32'h0);

    // Random periods and random ready
    ticks = 0; m_started = 0; m_drops = 0; rx_pkts = 0; rx = {};
    issued = 0; cyc = 0;
    while (issued < 100 && cyc < 20000) begin
      rpd = ($urandom_range(0, 3) == 0);
      rp  = {16'($urandom), $urandom};
      step(rpd, rp, $urandom_range(0, 3) != 0, 1);
      if (rpd) issued++;
      cyc++;
    end
    chk("t6_issued", issued, 100);
    for (int i = 0; i < 3 * LEN; i++) step(0, 48'h0, 1, 1);
    chk("t6_busy", {31'h0, busy}, 32'h0);
    chk("t6_pkts", rx_pkts, m_started);
    chk("t6_conserve", rx_pkts + m_drops, ticks);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/period_tag_tx.md
Name: period_tag_tx

Overview:
Transmit side for the frontend period timer's tick output. Each `period_done` pulse captures the 48-bit period count and sends it to the backend link as a fixed 8-byte time-tag packet: header, six period bytes MSB first, XOR checksum. The byte stream uses a valid/ready handshake. A one-deep pending slot absorbs a single period tick while a packet is in flight; ticks beyond that are dropped and flagged.

Parameters:
HDR_NIBBLE, 4'hF, upper nibble of the header byte.
PERIOD_W, 48, width of the period input. Fixed at 48; any other value is an elaboration error.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous reset, active-low. Asserted (0) at a rising edge returns all state to reset values.
period_done  in  1  single-cycle tick from the period timer.
period  in  48  period count; sampled in the cycle `period_done`=1.
tx_data  out  8  packet byte.
tx_valid  out  1  `tx_data` is valid.
tx_ready  in  1  downstream accepts the byte when `tx_valid` && `tx_ready`.
busy  out  1  high while a packet is loaded or the pending slot is full.
overrun  out  1  sticky; set on any dropped tick. Cleared only by reset.

Behaviour:
- Reset values: `tx_data`=0, `tx_valid`=0, `busy`=0, `overrun`=0, pending slot empty, state IDLE, byte index 0, drop flag 0.
- Packet format:
  - byte0 = {HDR_NIBBLE, 3'b000, drop}. `drop`=1 if at least one tick was dropped since the previous packet's byte0 was loaded; it clears when the next byte0 is loaded.
  - bytes1..6 = period[47:40] … period[7:0].
  - byte7 = XOR of bytes0..6.
- States:
  - IDLE: `tx_valid`=0. If the pending slot is full, load it into the tx register and go to SEND. Else if `period_done`=1, load `period` directly and go to SEND.
  - SEND: `tx_valid`=1, `tx_data` = byte[idx]. On handshake, idx++.
  - On handshake at idx=7: if the pending slot is full, or `period_done`=1 this cycle, load it and stay in SEND with idx=0 (back-to-back packets, no idle gap). Else go to IDLE.
- Latency: tick at cycle N with IDLE and slot empty → byte0 on `tx_data` with `tx_valid`=1 at N+1.
- `tx_data` and `tx_valid` are registered and held stable while `tx_valid` && !`tx_ready`. `tx_valid` never deasserts mid-packet.
- Tick while in SEND:
  - Slot empty: write to slot.
  - Slot full: discard the new tick, keep the older slot contents, set `overrun` and the drop flag.
- Tick in the same cycle the slot drains into the tx register: written to the slot, not dropped.
- Checksum is accumulated as each byte is loaded. It must equal the XOR of the transmitted bytes0..6.
- Reset mid-packet aborts the packet immediately: `tx_valid`=0 on the next cycle and the pending slot is discarded.
- `busy` = (state==SEND) | slot_full, registered.

Optional Feature:
Macro: `PERIOD_TAG_DROPCNT_EN`
- Defined:
  - Adds output `drop_count` [15:0]: counts dropped ticks, saturates at 16'hFFFF, reset to 0.
  - Packet becomes 10 bytes: bytes7..8 = `drop_count` MSB first, snapshotted when byte0 is loaded; byte9 = XOR of bytes0..8.
- Undefined: no `drop_count` port; 8-byte packet as above.

Test Plan:
- Reset release, `tx_ready`=1, tick with period=48'h0123_4567_89AB → bytes F0,01,23,45,67,89,AB,checksum on 8 consecutive cycles starting 1 cycle after the tick; then IDLE, `busy`=0.
- `tx_ready` toggling 1/0 every cycle during a packet → `tx_data` stable while stalled; 8 bytes in order; `tx_valid` continuous.
- Three ticks (period 1, 2, 3) 2 cycles apart, `tx_ready`=0 until the third tick → packet for 1, then packet for 2 with header F1, tick 3 dropped, `overrun`=1. With macro: `drop_count`=1 and bytes7..8 = 00,01.
- Tick coinciding with the handshake of byte7 → next packet's byte0 on the following cycle, no gap, no drop.
- `rst`=0 asserted at byte 3 with the slot full → `tx_valid`=0 the next cycle; after release, no residual packet; `overrun`=0.
- 100 random periods with random `tx_ready` → every received packet's checksum matches the XOR of its other bytes; sent count + drop count = tick count.
